// File: rtl/beat_pkg.sv
// Shared types for the beat arbiter: requester count,
// intensity levels and FSM state encoding.
package beat_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    INT_NONE = 2'b00,
    INT_L1   = 2'b01,
    INT_L2   = 2'b10,
    INT_L3   = 2'b11
  } intensity_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_GAP  = 2'b10
  } state_e;

  function automatic logic [1:0] lvl_at(
    input logic [5:0] v,
    input logic [1:0] i
  );
    case (i)
      2'd0:    lvl_at = v[1:0];
      2'd1:    lvl_at = v[3:2];
      2'd2:    lvl_at = v[5:4];
      default: lvl_at = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] lvl_max(
    input logic [1:0] a,
    input logic [1:0] b
  );
    lvl_max = (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] rr_next(
    input logic [1:0] i
  );
    rr_next = (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

endpackage

// File: rtl/beat_rr_pick.sv
// Combinational requester selection: round-robin from
// last_grant+1; with BEAT_INTENSITY_PRIO_EN defined only the
// loudest pending requesters compete.
// Ports: pending, last_grant, intensities -> valid, index.
module beat_rr_pick
  import beat_pkg::*;
(
  input  logic [2:0] pending,
  input  logic [1:0] last_grant,
  input  logic [5:0] intensities,
  output logic       valid,
  output logic [1:0] index
);

  logic [1:0] cand [3];
  logic [1:0] top;
  logic       found;

  always_comb begin
    cand[0] = rr_next(last_grant);
    cand[1] = rr_next(cand[0]);
    cand[2] = rr_next(cand[1]);
  end

  always_comb begin
    top = 2'b00;
`ifdef BEAT_INTENSITY_PRIO_EN
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pending[k] && lvl_at(intensities, 2'(k)) > top)
        top = lvl_at(intensities, 2'(k));
    end
`endif
    valid = |pending;
    index = 2'd0;
    found = 1'b0;
    // Candidates below the loudest level are skipped;
    // with top at zero every pending requester qualifies.
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && pending[cand[k]] &&
          lvl_at(intensities, cand[k]) >= top) begin
        index = cand[k];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/beat_arbiter.sv
// Beat arbiter: latches per-axis beat requests, grants one note
// at a time (IDLE/PLAY/GAP), merges repeats and counts drops.
// Ports: clk, rst (async, active-low), req[2:0],
// req_intensity[5:0] -> note_start, note_src, note_intensity,
// voice_busy, pending, drop_cnt.
// Build option: BEAT_INTENSITY_PRIO_EN (loudest request wins).
module beat_arbiter
  import beat_pkg::*;
#(
  parameter logic [15:0] DUR_L1  = 16'd1000,
  parameter logic [15:0] DUR_L2  = 16'd2000,
  parameter logic [15:0] DUR_L3  = 16'd4000,
  parameter logic [7:0]  HOLDOFF = 8'd5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic [5:0] req_intensity,
  output logic       note_start,
  output logic [1:0] note_src,
  output logic [1:0] note_intensity,
  output logic       voice_busy,
  output logic [2:0] pending,
  output logic [7:0] drop_cnt
);

  state_e      state;
  state_e      state_nx;
  logic [15:0] dur_cnt;
  logic [7:0]  hold_cnt;
  logic [1:0]  last_grant;
  logic [5:0]  stored;
  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic        grant;
  logic [1:0]  grant_lvl;
  logic [15:0] dur_sel;
  logic [2:0]  gmask;
  logic [2:0]  pend_base;
  logic [2:0]  pend_nx;
  logic [5:0]  stored_nx;
  logic [1:0]  merges;
  logic [8:0]  drop_sum;
  logic [7:0]  drop_nx;

  beat_rr_pick u_pick (
    .pending     (pending),
    .last_grant  (last_grant),
    .intensities (stored),
    .valid       (pick_valid),
    .index       (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (grant) state_nx = ST_PLAY;
      ST_PLAY:
        if (dur_cnt == 16'd0)
          state_nx = (HOLDOFF == 8'd0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (hold_cnt == 8'd0) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    grant      = (state == ST_IDLE) && pick_valid;
    voice_busy = (state == ST_PLAY);
  end

  always_comb begin
    grant_lvl = lvl_at(stored, pick_idx);
    case (grant_lvl)
      2'b01:   dur_sel = DUR_L1;
      2'b10:   dur_sel = DUR_L2;
      2'b11:   dur_sel = DUR_L3;
      default: dur_sel = 16'd0;
    endcase
  end

  // Counters hold the remaining cycles minus one so the
  // terminal value is zero and they never wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dur_cnt  <= 16'd0;
      hold_cnt <= 8'd0;
    end else begin
      case (state)
        ST_IDLE:
          if (grant)
            dur_cnt <= (dur_sel == 16'd0) ? 16'd0
                                          : dur_sel - 16'd1;
        ST_PLAY:
          if (dur_cnt != 16'd0)
            dur_cnt <= dur_cnt - 16'd1;
          else if (HOLDOFF != 8'd0)
            hold_cnt <= HOLDOFF - 8'd1;
        ST_GAP:
          if (hold_cnt != 8'd0)
            hold_cnt <= hold_cnt - 8'd1;
        default: ;
      endcase
    end
  end

  // The granted bit is cleared before new requests are applied,
  // so a same-cycle request re-latches instead of merging.
  always_comb begin
    gmask     = grant ? (3'b001 << pick_idx) : 3'b000;
    pend_base = pending & ~gmask;
    pend_nx   = pend_base;
    stored_nx = stored;
    merges    = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && req_intensity[2*i +: 2] != 2'b00) begin
        if (pend_base[i]) begin
          stored_nx[2*i +: 2] = lvl_max(stored[2*i +: 2],
                                        req_intensity[2*i +: 2]);
          merges = merges + 2'd1;
        end else begin
          stored_nx[2*i +: 2] = req_intensity[2*i +: 2];
          pend_nx[i] = 1'b1;
        end
      end
    end
    drop_sum = {1'b0, drop_cnt} + {7'd0, merges};
    drop_nx  = drop_sum[8] ? 8'hff : drop_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      note_start     <= 1'b0;
      note_src       <= 2'd0;
      note_intensity <= 2'd0;
      last_grant     <= 2'd2;
      pending        <= 3'b000;
      stored         <= 6'd0;
      drop_cnt       <= 8'd0;
    end else begin
      note_start <= grant;
      if (grant) begin
        note_src       <= pick_idx;
        note_intensity <= grant_lvl;
        last_grant     <= pick_idx;
      end
      pending  <= pend_nx;
      stored   <= stored_nx;
      drop_cnt <= drop_nx;
    end
  end

endmodule

// File: tb/tb_beat_arbiter.sv
// Randomized and directed bench for beat_arbiter against an
// edge-by-edge behavioural model of the note scheduler.
module tb_beat_arbiter;

  localparam int D1 = 4;
  localparam int D2 = 6;
  localparam int D3 = 8;
  localparam int HO = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] req = 3'b000;
  logic [5:0] req_intensity = 6'd0;
  logic       note_start;
  logic [1:0] note_src;
  logic [1:0] note_intensity;
  logic       voice_busy;
  logic [2:0] pending;
  logic [7:0] drop_cnt;

  int n_chk = 0;
  int n_fail = 0;

  beat_arbiter #(
    .DUR_L1  (16'(D1)),
    .DUR_L2  (16'(D2)),
    .DUR_L3  (16'(D3)),
    .HOLDOFF (8'(HO))
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_intensity  (req_intensity),
    .note_start     (note_start),
    .note_src       (note_src),
    .note_intensity (note_intensity),
    .voice_busy     (voice_busy),
    .pending        (pending),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  // model: edge index, pending set, stored levels, next edge
  // at which a grant may happen, last grant edge/length
  int n;
  bit mp [3];
  int ms [3];
  int mfree;
  int mg;
  int mdur;
  int mlast;
  int mdrop;
  int msrc;
  int mint;
  bit mstart;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int dur_of(input int l);
    return (l == 1) ? D1 : (l == 2) ? D2 : D3;
  endfunction

  function automatic int mpick();
    int top = 0;
`ifdef BEAT_INTENSITY_PRIO_EN
    for (int k = 0; k < 3; k++)
      if (mp[k] && ms[k] > top) top = ms[k];
`endif
    for (int k = 1; k <= 3; k++) begin
      int c = (mlast + k) % 3;
      if (mp[c] && ms[c] >= top) return c;
    end
    return -1;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 3; i++) begin
      mp[i] = 0;
      ms[i] = 0;
    end
    mfree = 0;
    mg = -1000;
    mdur = 0;
    mlast = 2;
    mdrop = 0;
    msrc = 0;
    mint = 0;
    mstart = 0;
  endtask

  task automatic medge(input logic [2:0] r,
                       input logic [5:0] ri);
    int c;
    mstart = 0;
    if (n >= mfree) begin
      c = mpick();
      if (c >= 0) begin
        mstart = 1;
        msrc = c;
        mint = ms[c];
        mp[c] = 0;
        mlast = c;
        mg = n;
        mdur = dur_of(mint);
        mfree = n + mdur + HO + 1;
      end
    end
    for (int i = 0; i < 3; i++) begin
      int lv = int'(ri[2*i +: 2]);
      if (r[i] && lv != 0) begin
        if (mp[i]) begin
          if (lv > ms[i]) ms[i] = lv;
          mdrop = (mdrop < 255) ? mdrop + 1 : 255;
        end else begin
          mp[i] = 1;
          ms[i] = lv;
        end
      end
    end
  endtask

  task automatic cmp_all();
    bit busy;
    busy = (n >= mg) && (n < mg + mdur);
    chk("note_start", 16'(note_start), 16'(mstart));
    chk("note_src", 16'(note_src), 16'(msrc));
    chk("note_int", 16'(note_intensity), 16'(mint));
    chk("voice_busy", 16'(voice_busy), 16'(busy));
    chk("pending", 16'(pending),
        16'({mp[2], mp[1], mp[0]}));
    chk("drop_cnt", 16'(drop_cnt), 16'(mdrop));
  endtask

  task automatic step(input logic [2:0] r,
                      input logic [5:0] ri);
    @(negedge clk);
    req = r;
    req_intensity = ri;
    @(posedge clk);
    medge(r, ri);
    #1;
    cmp_all();
    n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    req = 3'b000;
    req_intensity = 6'd0;
    mreset();
    #1;
    chk("rst_busy", 16'(voice_busy), 16'd0);
    chk("rst_pend", 16'(pending), 16'd0);
    chk("rst_start", 16'(note_start), 16'd0);
    chk("rst_drop", 16'(drop_cnt), 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
  endtask

  initial begin
    int cnt;
    int t0;
    int t1;
    int t2;
    logic [1:0] s0;
    logic [1:0] s1;
    logic [1:0] s2;
    n = 0;
    mreset();
    #1;
    cmp_all();
    chk("rst_src", 16'(note_src), 16'd0);
    #20;
    rst = 1'b1;

    // single request after ten quiet edges
    repeat (10) step(3'b000, 6'd0);
    step(3'b001, 6'b000001);
    step(3'b000, 6'd0);
    chk("s1_start", 16'(note_start), 16'd1);
    chk("s1_src", 16'(note_src), 16'd0);
    cnt = int'(voice_busy);
    repeat (12) begin
      step(3'b000, 6'd0);
      cnt += int'(voice_busy);
    end
    chk("s1_busy_len", 16'(cnt), 16'(D1));

    // three simultaneous requests: round-robin 0,1,2
    do_reset();
    step(3'b111, 6'b010101);
    t0 = -1;
    t1 = -1;
    t2 = -1;
    s0 = 2'd3;
    s1 = 2'd3;
    s2 = 2'd3;
    for (int k = 0; k < 30; k++) begin
      step(3'b000, 6'd0);
      if (note_start) begin
        if (t0 < 0) begin
          t0 = n; s0 = note_src;
        end else if (t1 < 0) begin
          t1 = n; s1 = note_src;
        end else if (t2 < 0) begin
          t2 = n; s2 = note_src;
        end
      end
    end
    chk("s2_src0", 16'(s0), 16'd0);
    chk("s2_src1", 16'(s1), 16'd1);
    chk("s2_src2", 16'(s2), 16'd2);
    chk("s2_between01", 16'(t1 - t0 - 1), 16'd6);
    chk("s2_between12", 16'(t2 - t1 - 1), 16'd6);

    // merges during PLAY keep the loudest level
    do_reset();
    step(3'b001, 6'b000001);
    step(3'b000, 6'd0);
    step(3'b010, 6'b000100);
    step(3'b010, 6'b001100);
    step(3'b010, 6'b000100);
    for (int k = 0; k < 12; k++) begin
      step(3'b000, 6'd0);
      if (note_start && note_src == 2'd1)
        chk("s3_int", 16'(note_intensity), 16'd3);
    end
    chk("s3_drop", 16'(drop_cnt), 16'd2);

    // intensity priority option
    do_reset();
    step(3'b011, 6'b001101);
    step(3'b000, 6'd0);
`ifdef BEAT_INTENSITY_PRIO_EN
    chk("s4_first", 16'(note_src), 16'd1);
`else
    chk("s4_first", 16'(note_src), 16'd0);
`endif
    repeat (20) step(3'b000, 6'd0);

    // reset mid-note, then a fresh request from Z
    step(3'b001, 6'b000011);
    step(3'b000, 6'd0);
    step(3'b010, 6'b000100);
    step(3'b000, 6'd0);
    chk("s5_busy_pre", 16'(voice_busy), 16'd1);
    do_reset();
    step(3'b100, 6'b010000);
    step(3'b000, 6'd0);
    chk("s5_start", 16'(note_start), 16'd1);
    chk("s5_src", 16'(note_src), 16'd2);
    repeat (15) step(3'b000, 6'd0);

    // drop counter saturation
    do_reset();
    repeat (150) step(3'b111, 6'b111111);
    chk("s6_sat", 16'(drop_cnt), 16'd255);
    repeat (5) step(3'b000, 6'd0);

    // random traffic
    do_reset();
    for (int k = 0; k < 600; k++) begin
      logic [2:0] r;
      r[0] = ($urandom_range(0, 3) == 0);
      r[1] = ($urandom_range(0, 3) == 0);
      r[2] = ($urandom_range(0, 3) == 0);
      step(r, 6'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/beat_arbiter.md
BEAT_ARBITER -- requirements
Module: beat_arbiter

Interface
REQ-001 Parameter DUR_L1, default 16'd1000, play length in clk cycles for intensity 2'b01.
REQ-002 Parameter DUR_L2, default 16'd2000, play length for intensity 2'b10.
REQ-003 Parameter DUR_L3, default 16'd4000, play length for intensity 2'b11.
REQ-004 Parameter HOLDOFF, default 8'd5, idle gap in cycles after each note; 0 means no gap.
REQ-005 clk  input  1  clock.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 req  input  3  per-axis beat strobes; bit i is requester i (0=X, 1=Y, 2=Z).
REQ-008 req_intensity  input  6  intensity of requester i on bits [2i+1:2i]; 2'b00 means none.
REQ-009 note_start  output  1  one-cycle pulse when a note is granted.
REQ-010 note_src  output  2  index of the granted requester; held until the next grant.
REQ-011 note_intensity  output  2  intensity of the granted note; held until the next grant.
REQ-012 voice_busy  output  1  high while a note is playing.
REQ-013 pending  output  3  latched, not-yet-granted requests.
REQ-014 drop_cnt  output  8  count of merged (dropped) requests; saturates at 255.

Function
REQ-015 On each edge, req[i] with nonzero intensity shall set pending[i] and store its intensity; req with intensity 2'b00 shall be ignored.
REQ-016 A req[i] arriving while pending[i] is already set shall keep the maximum of the stored and new intensities, and shall increment drop_cnt (saturating).
REQ-017 The FSM shall have three states: IDLE, PLAY and GAP; reset state is IDLE.
REQ-018 IDLE with any pending bit set: the arbiter shall select one requester, pulse note_start, update note_src and note_intensity, clear that pending bit, load the duration for its intensity and go to PLAY.
REQ-019 Arbitration order shall be round-robin, searching last_grant+1, last_grant+2, then last_grant, modulo 3.
REQ-020 PLAY shall hold voice_busy high for exactly DUR_Lx cycles, starting in the note_start cycle.
REQ-021 When the PLAY count expires, the FSM shall go to GAP for HOLDOFF cycles, or straight to IDLE if HOLDOFF=0.
REQ-022 While in GAP, voice_busy shall be 0 and no grant shall occur.
REQ-023 Latency: a req sampled at edge k (FSM in IDLE) shall produce note_start after edge k+1.
REQ-024 If the granted requester asserts req in the grant cycle, set wins: pending[i] is re-latched.
REQ-025 Requests arriving during PLAY or GAP shall only latch; they are granted on the first IDLE cycle.
REQ-026 Duration counter width shall be 16 bits and the holdoff counter width 8 bits; counters shall not wrap.

Reset
REQ-027 On rst low, immediately and in any state: note_start=0, note_src=0, note_intensity=0, voice_busy=0, pending=0, drop_cnt=0, FSM=IDLE, counters=0, last_grant=2 (so requester 0 is searched first).
REQ-028 Reset release mid-note shall not resume the aborted note.

Configuration
REQ-029 With BEAT_INTENSITY_PRIO_EN defined, the highest stored intensity among pending requesters shall win, with ties broken by round-robin; without it, arbitration shall be pure round-robin regardless of intensity.

Structure
REQ-030 Shared package beat_pkg shall hold: NUM_REQ=3, intensity encodings (NONE, L1, L2, L3) and the FSM state encoding.
REQ-031 A combinational sub-module beat_rr_pick (inputs pending, last_grant, intensities; outputs valid and index) shall contain the selection logic, including the macro-dependent priority.

Verification
REQ-032 Bench parameters DUR_L1=4, DUR_L2=6, DUR_L3=8, HOLDOFF=2. Single req[0] with intensity 01 at edge 10 -> note_start after edge 11, note_src=0, voice_busy high for 4 cycles, then 2 idle cycles.
REQ-033 req=3'b111, all intensity 01, from reset -> grants in order 0, 1, 2; each note_start is separated by 6 cycles.
REQ-034 req[1] pulsed 3 times with intensities 01, 11, 01 during PLAY -> one grant with note_intensity=11; drop_cnt=2.
REQ-035 req=3'b011 with intensities 01/11 -> without the macro src 0 is granted first; with BEAT_INTENSITY_PRIO_EN src 1 is granted first.
REQ-036 rst low in mid-PLAY -> voice_busy=0 and pending=0 asynchronously; after release, a req[2] is granted as src=2 with no residual note.
REQ-037 300 merged requests -> drop_cnt holds at 255.
